// File: rtl/instr_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath.
// The slave side is the sequencer; the master side is the datapath or a bench.
interface instr_sequencer_if #(parameter int OPW = 5);
  logic           run;
  logic [31:0]    ir;
  logic           mem_ready;
  logic           PCout, Zlowout, MDRout, Rout;
  logic           MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, Rin;
  logic           IncPC, read;
  logic [3:0]     reg_sel;
  logic [OPW-1:0] alu_op;
  logic           halted, fault;
  logic [15:0]    instr_count;

  modport slave (
    input  run, ir, mem_ready,
    output PCout, Zlowout, MDRout, Rout, MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, Rin,
           IncPC, read, reg_sel, alu_op, halted, fault, instr_count
  );

  modport master (
    output run, ir, mem_ready,
    input  PCout, Zlowout, MDRout, Rout, MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, Rin,
           IncPC, read, reg_sel, alu_op, halted, fault, instr_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Hardwired fetch/execute sequencer for register-register ALU instructions.
//
// state  | meaning
// IDLE   | waiting for run
// T0     | PC to MAR, Z <= PC+1
// T1     | memory read; waits for mem_ready, PC <= Z on exit
// T2     | MDR to IR
// T3     | decode; Y <= R[Rb], or complete nop/halt
// T4     | Z <= Y op R[Rc]
// T5     | R[Ra] <= Z, complete
// HALTED | sticky after halt
// FAULT  | sticky after memory wait timeout
module instr_sequencer #(
  parameter int OPW      = 5,
  parameter int WAIT_MAX = 8
) (
  input logic clk,
  input logic reset,
  instr_sequencer_if.slave bus
);
  localparam int WW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, HALTED, FAULT} state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   wait_cnt;
  logic [15:0]     count_q;
  logic            complete;
  logic [OPW-1:0]  opcode;
  logic [3:0]      ra, rb, rc;
  logic            unused_ir;

  assign opcode    = bus.ir[31 -: OPW];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];
  assign bus.instr_count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      count_q  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == T1 && !bus.mem_ready) ? wait_cnt + WW'(1) : '0;
      if (complete) count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    state_nx    = state;
    complete    = 1'b0;
    bus.PCout   = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MDRout  = 1'b0;
    bus.Rout    = 1'b0;
    bus.MARIn   = 1'b0;
    bus.ZIn     = 1'b0;
    bus.PCIn    = 1'b0;
    bus.MDRIn   = 1'b0;
    bus.IRIn    = 1'b0;
    bus.YIn     = 1'b0;
    bus.Rin     = 1'b0;
    bus.IncPC   = 1'b0;
    bus.read    = 1'b0;
    bus.reg_sel = 4'd0;
    bus.alu_op  = '0;
    bus.halted  = 1'b0;
    bus.fault   = 1'b0;
    case (state)
      IDLE: if (bus.run) state_nx = T0;
      T0: begin
        bus.PCout = 1'b1;
        bus.MARIn = 1'b1;
        bus.IncPC = 1'b1;
        bus.ZIn   = 1'b1;
        state_nx  = T1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.read    = 1'b1;
        bus.MDRIn   = 1'b1;
        if (bus.mem_ready) begin
          bus.PCIn = 1'b1;
          state_nx = T2;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = FAULT;
        end
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRIn   = 1'b1;
        state_nx   = T3;
      end
      T3: begin
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_OR) begin
          bus.Rout    = 1'b1;
          bus.YIn     = 1'b1;
          bus.reg_sel = rb;
          state_nx    = T4;
        end else if (opcode == OP_HALT) begin
          complete = 1'b1;
          state_nx = HALTED;
        end else begin
          // unknown opcodes retire as nop
          complete = 1'b1;
          state_nx = bus.run ? T0 : IDLE;
        end
      end
      T4: begin
        bus.Rout    = 1'b1;
        bus.ZIn     = 1'b1;
        bus.reg_sel = rc;
        bus.alu_op  = opcode;
        state_nx    = T5;
      end
      T5: begin
        bus.Zlowout = 1'b1;
        bus.Rin     = 1'b1;
        bus.reg_sel = ra;
        complete    = 1'b1;
        state_nx    = bus.run ? T0 : IDLE;
      end
      HALTED: bus.halted = 1'b1;
      FAULT:  bus.fault  = 1'b1;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: per-cycle control words are predicted
// from an instruction-level model (phase list per opcode, wait count, run).
module tb_instr_sequencer;
  localparam logic [23:0] PCOUT  = 24'h800000, ZLOW  = 24'h400000, MDROUT = 24'h200000,
                          ROUT   = 24'h100000, MARIN = 24'h080000, ZIN    = 24'h040000,
                          PCIN   = 24'h020000, MDRIN = 24'h010000, IRIN   = 24'h008000,
                          YIN    = 24'h004000, RIN   = 24'h002000, INCPC  = 24'h001000,
                          READ   = 24'h000800, HALTB = 24'h000002, FAULTB = 24'h000001;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b01001,
                         OP_OR = 5'b01010, OP_NOP = 5'b11010, OP_HALT = 5'b11011;

  logic clk;
  logic reset;
  int total;
  int bad;
  logic [15:0] exp_cnt;

  instr_sequencer_if #(.OPW(5)) bus ();
  instr_sequencer #(.OPW(5), .WAIT_MAX(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] obs_vec();
    return {bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.MARIn, bus.ZIn, bus.PCIn,
            bus.MDRIn, bus.IRIn, bus.YIn, bus.Rin, bus.IncPC, bus.read,
            bus.reg_sel, bus.alu_op, bus.halted, bus.fault};
  endfunction

  function automatic logic [23:0] sel(input logic [3:0] r);
    return 24'(r) << 7;
  endfunction

  function automatic logic [23:0] opf(input logic [4:0] op);
    return 24'(op) << 2;
  endfunction

  // Called just after a falling edge with inputs already applied.
  task automatic step(input logic [23:0] exp, input string nm, input bit done);
    logic [23:0] o;
    #1;
    o = obs_vec();
    total++;
    if (o !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, o, exp);
    end
    total++;
    if (bus.instr_count !== exp_cnt) begin
      bad++;
      $display("FAIL %s_count: got %h want %h", nm, bus.instr_count, exp_cnt);
    end
    @(posedge clk);
    if (done) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
  endtask

  task automatic start_from_idle();
    bus.run = 1'b0;
    step(24'h0, "idle_hold", 1'b0);
    bus.run = 1'b1;
    step(24'h0, "idle_go", 1'b0);
  endtask

  // Expects the DUT to be entering T0; run is held high until the execute phase.
  task automatic do_instr(input logic [31:0] iv, input int waits, input bit run_end);
    logic [4:0] op;
    bit alu;
    op  = iv[31:27];
    alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    bus.ir = iv;
    bus.run = 1'b1;
    bus.mem_ready = 1'($urandom_range(0, 1));
    step(PCOUT | MARIN | INCPC | ZIN, "t0", 1'b0);
    for (int i = 0; i < waits; i++) begin
      bus.mem_ready = 1'b0;
      step(ZLOW | READ | MDRIN, "t1_wait", 1'b0);
    end
    bus.mem_ready = 1'b1;
    step(ZLOW | READ | MDRIN | PCIN, "t1_ready", 1'b0);
    bus.mem_ready = 1'($urandom_range(0, 1));
    step(MDROUT | IRIN, "t2", 1'b0);
    if (alu) begin
      step(ROUT | YIN | sel(iv[22:19]), "t3_alu", 1'b0);
      bus.run = run_end;
      step(ROUT | ZIN | sel(iv[18:15]) | opf(op), "t4", 1'b0);
      step(ZLOW | RIN | sel(iv[26:23]), "t5", 1'b1);
    end else if (op == OP_HALT) begin
      bus.run = run_end;
      step(24'h0, "t3_halt", 1'b1);
    end else begin
      bus.run = run_end;
      step(24'h0, "t3_nop", 1'b1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_cnt = 16'h0;
    #1;
    total++;
    if (obs_vec() !== 24'h0 || bus.instr_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_async: got %h/%h want 0/0", obs_vec(), bus.instr_count);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.run = 1'b0;
    step(24'h0, "idle_after_reset", 1'b0);
  endtask

  function automatic logic [31:0] rand_alu();
    logic [31:0] v;
    logic [4:0] ops [4];
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
    v = $urandom;
    v[31:27] = ops[$urandom_range(0, 3)];
    return v;
  endfunction

  task automatic test_reset();
    #1;
    total++;
    if (obs_vec() !== 24'h0 || bus.instr_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got %h/%h want 0/0", obs_vec(), bus.instr_count);
    end
    @(negedge clk);
    reset = 1'b0;
    step(24'h0, "idle_stay", 1'b0);
    step(24'h0, "idle_stay2", 1'b0);
  endtask

  task automatic test_and();
    start_from_idle();
    do_instr(32'h4A920000, 0, 1'b1);
  endtask

  task automatic test_mem_wait();
    do_instr(rand_alu(), 3, 1'b0);
    step(24'h0, "wait_then_idle", 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [4:0] op;
    start_from_idle();
    for (int n = 0; n < 40; n++) begin
      v = rand_alu();
      case ($urandom_range(0, 5))
        0: v[31:27] = OP_NOP;
        1: begin
          op = 5'($urandom);
          while (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR || op == OP_HALT)
            op = 5'($urandom);
          v[31:27] = op;
        end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        do_instr(v, $urandom_range(0, 7), 1'b0);
        start_from_idle();
      end else begin
        do_instr(v, $urandom_range(0, 7), 1'b1);
      end
    end
    do_instr(rand_alu(), 7, 1'b0);
    step(24'h0, "random_end_idle", 1'b0);
  endtask

  task automatic test_run_stop();
    start_from_idle();
    do_instr(rand_alu(), 1, 1'b0);
    bus.run = 1'b0;
    step(24'h0, "stop_idle", 1'b0);
    step(24'h0, "stop_idle2", 1'b0);
  endtask

  task automatic test_reset_midop();
    logic [31:0] v;
    v = rand_alu();
    bus.ir = v;
    start_from_idle();
    bus.mem_ready = 1'b1;
    step(PCOUT | MARIN | INCPC | ZIN, "mid_t0", 1'b0);
    step(ZLOW | READ | MDRIN | PCIN, "mid_t1", 1'b0);
    step(MDROUT | IRIN, "mid_t2", 1'b0);
    step(ROUT | YIN | sel(v[22:19]), "mid_t3", 1'b0);
    #1;
    total++;
    if (obs_vec() !== (ROUT | ZIN | sel(v[18:15]) | opf(v[31:27]))) begin
      bad++;
      $display("FAIL mid_t4: got %h want %h", obs_vec(), ROUT | ZIN | sel(v[18:15]) | opf(v[31:27]));
    end
    #2;
    do_reset();
  endtask

  task automatic test_wrap();
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    exp_cnt = 16'hFFFF;
    start_from_idle();
    do_instr(32'hD0000000, 0, 1'b0);
    bus.run = 1'b0;
    step(24'h0, "wrap_idle", 1'b0);
  endtask

  task automatic test_nop();
    start_from_idle();
    do_instr(32'hD0000000, 2, 1'b1);
    do_instr(32'h4A920000, 0, 1'b0);
    step(24'h0, "nop_idle", 1'b0);
  endtask

  task automatic test_timeout();
    start_from_idle();
    bus.mem_ready = 1'b1;
    step(PCOUT | MARIN | INCPC | ZIN, "to_t0", 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = 1'b0;
      step(ZLOW | READ | MDRIN, "to_t1", 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      bus.run = 1'($urandom_range(0, 1));
      bus.mem_ready = 1'($urandom_range(0, 1));
      step(FAULTB, "fault_sticky", 1'b0);
    end
    do_reset();
  endtask

  task automatic test_halt();
    start_from_idle();
    do_instr(32'hD8000000, 1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bus.run = 1'(i % 2);
      bus.mem_ready = 1'($urandom_range(0, 1));
      step(HALTB, "halted_sticky", 1'b0);
    end
    do_reset();
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 16'h0;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.ir = 32'h0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_and();
    test_mem_wait();
    test_random();
    test_run_stop();
    test_reset_midop();
    test_nop();
    test_wrap();
    test_timeout();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
